// File: rtl/mac_stream_if.sv
// Handshake and data bundle between the sample/coefficient streamer, the MAC
// engine and the result consumer.
interface mac_stream_if #(
  parameter int N     = 16,
  parameter int CNT_W = 8
);
  logic                in_valid;
  logic                in_ready;
  logic                in_last;
  logic signed [N-1:0] A;
  logic signed [N-1:0] B;
  logic                out_valid;
  logic                out_ready;
  logic signed [N-1:0] P;
  logic                ovf;
  logic [CNT_W-1:0]    cnt;

  modport master (
    output in_valid, in_last, A, B, out_ready,
    input  in_ready, out_valid, P, ovf, cnt
  );

  modport slave (
    input  in_valid, in_last, A, B, out_ready,
    output in_ready, out_valid, P, ovf, cnt
  );
endinterface

// File: rtl/mac_stream.sv
// Streaming three-stage signed multiply-accumulate with framed results,
// round-half-up scaling, saturation, sticky overflow and term counting.
module mac_stream #(
  parameter int N     = 16,
  parameter int ACC_W = 40,
  parameter int FRAC  = 15,
  parameter int CNT_W = 8
) (
  input logic         clk,
  input logic         arst_n,
  input logic         ce,
  mac_stream_if.slave bus
);
  localparam int RSH = (FRAC > 0) ? FRAC - 1 : 0;
  localparam logic signed [ACC_W:0] RND =
    (FRAC > 0) ? ({{ACC_W{1'b0}}, 1'b1} << RSH) : {(ACC_W+1){1'b0}};
  localparam logic signed [ACC_W:0] P_MAX = {{(ACC_W-N+2){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACC_W:0] P_MIN = {{(ACC_W-N+2){1'b1}}, {(N-1){1'b0}}};

  logic                    rdy_r;
  logic                    stall_s;
  logic                    accept_s;
  logic                    s1_v_r, s1_last_r;
  logic signed [N-1:0]     s1_a_r, s1_b_r;
  logic                    s2_v_r, s2_last_r;
  logic signed [2*N-1:0]   s2_p_r;
  logic                    s3_v_r, s3_last_r;
  logic signed [ACC_W-1:0] s3_p_r;
  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] sum_s;
  logic [CNT_W-1:0]        cnt_r, cnt_inc_s;
  logic                    sticky_r, wrap_s;
  logic signed [ACC_W:0]   rnd_s, shf_s;
  logic                    sat_hi_s, sat_lo_s;
  logic [N-1:0]            p_fmt_s;
  logic                    out_valid_r, ovf_r;
  logic [N-1:0]            p_r;
  logic [CNT_W-1:0]        cnt_out_r;

  assign stall_s      = !ce || (out_valid_r && !bus.out_ready);
  assign bus.in_ready = rdy_r && !stall_s;
  assign accept_s     = bus.in_valid && bus.in_ready;

  assign sum_s     = acc_r + s3_p_r;
  assign wrap_s    = (acc_r[ACC_W-1] == s3_p_r[ACC_W-1]) && (sum_s[ACC_W-1] != acc_r[ACC_W-1]);
  assign cnt_inc_s = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

  // One guard bit above the accumulator so the rounding constant never wraps.
  assign rnd_s    = {sum_s[ACC_W-1], sum_s} + RND;
  assign shf_s    = rnd_s >>> FRAC;
  assign sat_hi_s = shf_s > P_MAX;
  assign sat_lo_s = shf_s < P_MIN;

  // Clamp the scaled sum into the N-bit signed output range.
  always_comb begin
    p_fmt_s = shf_s[N-1:0];
    if (sat_hi_s) begin
      p_fmt_s = P_MAX[N-1:0];
    end else if (sat_lo_s) begin
      p_fmt_s = P_MIN[N-1:0];
    end else begin
      p_fmt_s = shf_s[N-1:0];
    end
  end

  // Pipeline, accumulator and output register; a stall freezes every stage.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rdy_r       <= 1'b0;
      s1_v_r      <= 1'b0;
      s1_last_r   <= 1'b0;
      s1_a_r      <= {N{1'b0}};
      s1_b_r      <= {N{1'b0}};
      s2_v_r      <= 1'b0;
      s2_last_r   <= 1'b0;
      s2_p_r      <= {(2*N){1'b0}};
      s3_v_r      <= 1'b0;
      s3_last_r   <= 1'b0;
      s3_p_r      <= {ACC_W{1'b0}};
      acc_r       <= {ACC_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      sticky_r    <= 1'b0;
      out_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
      p_r         <= {N{1'b0}};
      cnt_out_r   <= {CNT_W{1'b0}};
    end else begin
      if (ce) begin
        rdy_r <= 1'b1;
      end
      if (!stall_s) begin
        s1_v_r    <= accept_s;
        s1_last_r <= bus.in_last;
        s1_a_r    <= bus.A;
        s1_b_r    <= bus.B;
        s2_v_r    <= s1_v_r;
        s2_last_r <= s1_last_r;
        s2_p_r    <= (2*N)'(s1_a_r) * (2*N)'(s1_b_r);
        s3_v_r    <= s2_v_r;
        s3_last_r <= s2_last_r;
        s3_p_r    <= ACC_W'(s2_p_r);
        if (s3_v_r) begin
          if (s3_last_r) begin
            acc_r     <= {ACC_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            sticky_r  <= 1'b0;
            p_r       <= p_fmt_s;
            ovf_r     <= sat_hi_s || sat_lo_s || sticky_r || wrap_s;
            cnt_out_r <= cnt_inc_s;
          end else begin
            acc_r    <= sum_s;
            cnt_r    <= cnt_inc_s;
            sticky_r <= sticky_r || wrap_s;
          end
        end
        out_valid_r <= s3_v_r && s3_last_r;
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.P         = p_r;
  assign bus.ovf       = ovf_r;
  assign bus.cnt       = cnt_out_r;
endmodule

// File: tb/tb_mac_stream.sv
// Self-checking bench for mac_stream: directed vector table, multi-cycle
// corner sequences and randomized frames against an arithmetic model.
module tb_mac_stream;
  localparam int N     = 16;
  localparam int ACC_W = 40;
  localparam int FRAC  = 15;
  localparam int CNT_W = 8;

  typedef logic [N+CNT_W:0] res_t;
  typedef struct {
    int                  nb;
    logic signed [N-1:0] a [4];
    logic signed [N-1:0] b [4];
    res_t                want;
  } vec_t;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic ce = 1'b1;
  int   total = 0;
  int   bad = 0;
  bit   rnd_bp = 1'b0;
  res_t got [$];
  res_t exp_q [$];
  logic signed [N-1:0] fa [0:1023];
  logic signed [N-1:0] fb [0:1023];
  vec_t vt [8];

  always #5 clk = ~clk;

  mac_stream_if #(.N(N), .CNT_W(CNT_W)) bus ();

  mac_stream #(.N(N), .ACC_W(ACC_W), .FRAC(FRAC), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .ce     (ce),
    .bus    (bus)
  );

  // A result transfers on the coming edge when this holds at the falling edge.
  always @(negedge clk) begin
    if (arst_n && ce && bus.out_valid && bus.out_ready)
      got.push_back({bus.P, bus.ovf, bus.cnt});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
    end
  endtask

  // Reference: exact integer dot product, 40-bit wrap, round half up, clamp.
  function automatic res_t model(input int off, input int n);
    longint lim = longint'(1) <<< (ACC_W - 1);
    longint acc = 0;
    longint s, r, q;
    logic wr = 1'b0;
    logic sat = 1'b0;
    logic [N-1:0] p;
    logic [CNT_W-1:0] c;
    longint pmax = (longint'(1) <<< (N - 1)) - 1;
    longint pmin = -(longint'(1) <<< (N - 1));
    for (int i = 0; i < n; i++) begin
      s = acc + longint'(fa[off+i]) * longint'(fb[off+i]);
      if (s >= lim) begin
        wr = 1'b1;
        s = s - 2 * lim;
      end else if (s < -lim) begin
        wr = 1'b1;
        s = s + 2 * lim;
      end
      acc = s;
    end
    r = acc + ((FRAC > 0) ? (longint'(1) <<< (FRAC - 1)) : 0);
    q = r >>> FRAC;
    if (q > pmax) begin
      p = pmax[N-1:0];
      sat = 1'b1;
    end else if (q < pmin) begin
      p = pmin[N-1:0];
      sat = 1'b1;
    end else begin
      p = q[N-1:0];
    end
    if (n >= (1 << CNT_W) - 1) c = {CNT_W{1'b1}};
    else c = n[CNT_W-1:0];
    return {p, wr | sat, c};
  endfunction

  function automatic logic signed [N-1:0] rval();
    logic signed [N-1:0] v;
    case ($urandom_range(0, 3))
      0: v = 16'sh8000;
      1: v = 16'sd32767;
      default: v = N'($urandom);
    endcase
    return v;
  endfunction

  task automatic send_beat(input logic signed [N-1:0] a, input logic signed [N-1:0] b,
                           input logic last, output int waits);
    int w = 0;
    bit took = 1'b0;
    bus.in_valid = 1'b1;
    bus.A = a;
    bus.B = b;
    bus.in_last = last;
    while (!took && w < 100) begin
      @(negedge clk);
      took = bus.in_ready;
      @(posedge clk);
      #1;
      if (!took) w++;
      if (rnd_bp) bus.out_ready = 1'($urandom_range(0, 1));
    end
    if (!took) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no in_ready want accept");
    end
    bus.in_valid = 1'b0;
    waits = w;
  endtask

  task automatic send_frame(input int off, input int n, output int waits);
    int w;
    waits = 0;
    for (int j = 0; j < n; j++) begin
      send_beat(fa[off+j], fb[off+j], (j == n - 1), w);
      waits += w;
    end
  endtask

  task automatic wait_result(output res_t r, output bit ok);
    int w = 0;
    while (got.size() == 0 && w < 300) begin
      @(posedge clk);
      #1;
      if (rnd_bp) bus.out_ready = 1'($urandom_range(0, 1));
      w++;
    end
    if (got.size() == 0) begin
      total++;
      bad++;
      $display("FAIL result_timeout: got none want one result");
      r = '0;
      ok = 1'b0;
    end else begin
      r = got.pop_front();
      ok = 1'b1;
    end
  endtask

  initial begin
    res_t r;
    res_t rx, ry;
    bit ok;
    int w;
    int n;

    vt[0] = '{1, '{16'sd16384, 16'sd0, 16'sd0, 16'sd0}, '{16'sd16384, 16'sd0, 16'sd0, 16'sd0},
              {16'sd8192, 1'b0, 8'd1}};
    vt[1] = '{4, '{16'sd16384, -16'sd16384, 16'sd8192, 16'sd100},
                 '{16'sd16384, 16'sd16384, 16'sd8192, 16'sd0}, {16'sd2048, 1'b0, 8'd4}};
    vt[2] = '{1, '{16'sh8000, 16'sd0, 16'sd0, 16'sd0}, '{16'sh8000, 16'sd0, 16'sd0, 16'sd0},
              {16'sd32767, 1'b1, 8'd1}};
    vt[3] = '{4, '{16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767},
                 '{16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767}, {16'sd32767, 1'b1, 8'd4}};
    vt[4] = '{1, '{16'sd1, 16'sd0, 16'sd0, 16'sd0}, '{16'sd16384, 16'sd0, 16'sd0, 16'sd0},
              {16'sd1, 1'b0, 8'd1}};
    vt[5] = '{1, '{-16'sd1, 16'sd0, 16'sd0, 16'sd0}, '{16'sd16384, 16'sd0, 16'sd0, 16'sd0},
              {16'sd0, 1'b0, 8'd1}};
    vt[6] = '{1, '{16'sd1, 16'sd0, 16'sd0, 16'sd0}, '{16'sd8191, 16'sd0, 16'sd0, 16'sd0},
              {16'sd0, 1'b0, 8'd1}};
    vt[7] = '{2, '{16'sh8000, 16'sh8000, 16'sd0, 16'sd0}, '{16'sd32767, 16'sd32767, 16'sd0, 16'sd0},
              {16'sh8000, 1'b1, 8'd2}};

    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.out_ready = 1'b1;

    // reset state
    #12;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_result", {bus.P, bus.ovf, bus.cnt}, '0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    check("ready_before_edge", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    check("ready_after_edge", bus.in_ready, 1'b1);

    // latency of a single-beat frame
    send_beat(16'sd16384, 16'sd16384, 1'b1, w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("lat_k2_not_valid", bus.out_valid, 1'b0);
    @(posedge clk); #1;
    check("lat_k3_valid", bus.out_valid, 1'b1);
    check("lat_k3_result", {bus.P, bus.ovf, bus.cnt}, {16'sd8192, 1'b0, 8'd1});
    wait_result(r, ok);
    if (ok) check("lat_popped", r, {16'sd8192, 1'b0, 8'd1});

    // directed vectors
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < vt[i].nb; j++) begin
        fa[j] = vt[i].a[j];
        fb[j] = vt[i].b[j];
      end
      send_frame(0, vt[i].nb, w);
      check($sformatf("ready_hi_vec%0d", i), w, 0);
      wait_result(r, ok);
      if (ok) check($sformatf("vec%0d", i), r, vt[i].want);
    end

    // backpressure: 2-beat frame then 3-beat frame with the consumer stalled
    bus.out_ready = 1'b0;
    fa[0] = 16'sd16384;  fb[0] = 16'sd16384;
    fa[1] = 16'sd16384;  fb[1] = 16'sd16384;
    fa[2] = 16'sd100;    fb[2] = 16'sd200;
    fa[3] = -16'sd300;   fb[3] = 16'sd50;
    fa[4] = 16'sd1000;   fb[4] = 16'sd1000;
    rx = model(0, 2);
    ry = model(2, 3);
    send_frame(0, 2, w);
    send_frame(2, 3, w);
    repeat (6) @(posedge clk);
    #1;
    check("bp_ready_low", bus.in_ready, 1'b0);
    check("bp_first_held", {bus.out_valid, bus.P, bus.ovf, bus.cnt}, {1'b1, rx});
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("bp_second_held", {bus.out_valid, bus.P, bus.ovf, bus.cnt}, {1'b1, ry});
    check("bp_one_taken", got.size(), 1);
    bus.out_ready = 1'b1;
    wait_result(r, ok);
    if (ok) check("bp_first", r, rx);
    wait_result(r, ok);
    if (ok) check("bp_second", r, ry);
    repeat (4) @(posedge clk);
    #1;
    check("bp_no_dup", {bus.out_valid, 31'(got.size())}, '0);

    // reset mid-frame discards the partial sum
    send_beat(16'sd16384, 16'sd16384, 1'b0, w);
    send_beat(16'sd16384, 16'sd16384, 1'b0, w);
    arst_n = 1'b0;
    #2;
    check("mid_rst_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    arst_n = 1'b1;
    send_beat(16'sd16384, 16'sd16384, 1'b1, w);
    wait_result(r, ok);
    if (ok) check("mid_rst_result", r, {16'sd8192, 1'b0, 8'd1});
    repeat (4) @(posedge clk);
    #1;
    check("mid_rst_single", got.size(), 0);

    // ce drop mid-frame only pauses
    fa[0] = 16'sd300;    fb[0] = -16'sd700;
    fa[1] = 16'sd12000;  fb[1] = 16'sd9000;
    fa[2] = -16'sd5000;  fb[2] = 16'sd4000;
    fa[3] = 16'sd7;      fb[3] = 16'sd7;
    send_beat(fa[0], fb[0], 1'b0, w);
    send_beat(fa[1], fb[1], 1'b0, w);
    ce = 1'b0;
    #1;
    check("ce_ready_low", bus.in_ready, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    ce = 1'b1;
    send_beat(fa[2], fb[2], 1'b0, w);
    send_beat(fa[3], fb[3], 1'b1, w);
    wait_result(r, ok);
    if (ok) check("ce_drop", r, model(0, 4));

    // long frame: accumulator wrap and counter saturation
    for (int j = 0; j < 600; j++) begin
      fa[j] = 16'sh8000;
      fb[j] = 16'sh8000;
    end
    send_frame(0, 600, w);
    wait_result(r, ok);
    if (ok) check("long_wrap_cnt_sat", r, model(0, 600));

    // randomized frames with random consumer backpressure
    rnd_bp = 1'b1;
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) begin
        fa[j] = rval();
        fb[j] = rval();
      end
      send_frame(0, n, w);
      exp_q.push_back(model(0, n));
    end
    for (int k = 0; k < 40; k++) begin
      wait_result(r, ok);
      if (ok) check($sformatf("rand%0d", k), r, exp_q[k]);
    end
    rnd_bp = 1'b0;
    bus.out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("rand_no_extra", got.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/mac_stream.md
Name: mac_stream

Overview:
- Streaming, fully pipelined signed multiply-accumulate engine. Successor to the single-word MAC.
- Adds:
  - valid/ready handshakes on input and output, with backpressure;
  - frame delimiting by an in_last flag (no separate load strobe);
  - a parametrised accumulator width and fixed-point output scaling;
  - round-half-up and saturation, with a sticky overflow flag and a term count.
- Sits between a sample/coefficient streamer and the result bus of the filter/dot-product datapath.

Parameters:
- N, 16: width of A, B and P (signed two's complement).
- ACC_W, 40: accumulator width; must be >= 2*N.
- FRAC, 15: right shift applied to the accumulator to form P; legal range 0..2*N-1.
- CNT_W, 8: width of the term counter.

Ports:
- clk  in  1  clock; all state updates on rising edge only.
- arst_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable; 0 freezes all state and forces in_ready=0.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine can accept a beat.
- in_last  in  1  beat is the final term of the current dot product.
- A  in  N  signed operand.
- B  in  N  signed operand.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- P  out  N  scaled, rounded, saturated result.
- ovf  out  1  result was saturated or the accumulator wrapped during this frame.
- cnt  out  CNT_W  number of terms in this frame, saturating at 2^CNT_W-1.

Behaviour:
Reset:
- Asynchronous, active low, clock is clk.
- All pipeline valids, the accumulator, the term counter, P, ovf, cnt and out_valid reset to 0.
- in_ready becomes 1 on the first edge after release, provided ce=1.
- Reset mid-frame discards the partial sum; no result is emitted for that frame.

Stall and handshake:
- stall = !ce | (out_valid & !out_ready). in_ready = !stall, driven combinationally.
- Accept a beat when in_valid & in_ready. In_ready does not depend on in_valid.
- While stalled, every stage holds its contents, including valid bits.

Pipeline (three stages, each with its own valid bit; bubbles never modify the accumulator or the counter):
- S1 registers A, B and in_last.
- S2 registers the full 2N-bit signed product.
- S3 sign-extends the product to ACC_W and forms sum = acc + product.
  - Wrap detection: the operands have the same sign and the sum's sign differs. Detection sets a sticky frame-overflow bit.
  - The counter increments and saturates at all-ones.
  - Non-last beat: acc <= sum.
  - Last beat: acc <= 0, counter <= 0, sticky bit <= 0. The output register loads from sum (next item).

Output formatting, applied to sum on the last beat:
- Round: r = sum + 2^(FRAC-1) when FRAC > 0; r = sum when FRAC = 0. Use an ACC_W+1 bit intermediate so rounding cannot wrap.
- Shift: arithmetic right shift of r by FRAC.
- Saturate to the range [-2^(N-1), 2^(N-1)-1].
- ovf = saturated | sticky | (wrap on this beat).
- cnt = incremented count, including the last beat.

Output register and latency:
- Last beat accepted at edge k: out_valid is high after edge k+3, assuming no stall.
- Out_valid clears on the edge where out_valid & out_ready, unless a new result loads on the same edge; in that case it stays 1 with the new data.
- P, ovf and cnt hold their last values when out_valid=0.
- Next frame: the first beat may be accepted on the cycle after the last beat. Back-to-back frames sustain one beat per cycle.
- Single-beat frame (in_last on the first beat) is legal; its result is that product, formatted as above.
- A ce drop mid-frame only pauses the engine; the sum is unaffected.

Test Plan:
- Defaults; single beat A=16384, B=16384, last -> after 3 edges P=8192, ovf=0, cnt=1.
- Four-beat frame of (A,B) pairs (16384,16384), (-16384,16384), (8192,8192), (100,0) -> P=2048, ovf=0, cnt=4; in_ready stays high throughout.
- Saturation: A=B=-32768, single beat -> P=32767, ovf=1.
- Second saturation: 4 beats of A=B=32767 -> P=32767, ovf=1.
- Rounding:
  - A=1, B=16384 -> P=1.
  - A=-1, B=16384 -> P=0.
  - A=1, B=8191 -> P=0.
- Backpressure: hold out_ready=0 while streaming a 2-beat frame then a 3-beat frame.
  - After the first result: in_ready falls and the pipeline freezes.
  - Raise out_ready for 1 cycle: the second result appears with the correct value; no beat is lost or duplicated.
- Reset and enable:
  - Assert arst_n=0 after 2 of 4 beats, release, then send a 1-beat frame A=B=16384 -> P=8192, cnt=1 (old partial sum gone).
  - Separately, drop ce for 5 cycles mid-frame -> same result as without the ce drop.
